// File: rtl/apb_led_pwm_pkg.sv
// Shared constants and address decode for the apb_led_pwm LED PWM peripheral.
package apb_led_pwm_pkg;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_PRESCALE = 8'h04;
    localparam logic [7:0] ADDR_DUTY_LO  = 8'h08;
    localparam logic [7:0] ADDR_DUTY_HI  = 8'h0C;
    localparam logic [7:0] ADDR_STATUS   = 8'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_INV    = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam logic [7:0] PWM_PERIOD_MAX = 8'd254;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_PRESCALE,
        REG_DUTY_LO,
        REG_DUTY_HI,
        REG_STATUS,
        REG_NONE
    } reg_sel_e;

    // Decode on the word index only; byte lanes and upper address bits do not matter.
    function automatic reg_sel_e decode_reg(input logic [5:0] word);
        case (word)
            ADDR_CTRL[7:2]:     return REG_CTRL;
            ADDR_PRESCALE[7:2]: return REG_PRESCALE;
            ADDR_DUTY_LO[7:2]:  return REG_DUTY_LO;
            ADDR_DUTY_HI[7:2]:  return REG_DUTY_HI;
            ADDR_STATUS[7:2]:   return REG_STATUS;
            default:            return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 0..254 period counter; wrap_o marks the tick that ends a period.
module pwm_timebase
    import apb_led_pwm_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [15:0] prescale_i,
    output logic [7:0]  cnt_o,
    output logic        wrap_o
);

    logic [15:0] presc_q, presc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        tick;

    // A prescale lowered below the running count lets the prescaler roll over 0xFFFF.
    always_comb begin
        tick    = en_i && (presc_q == prescale_i);
        wrap_o  = tick && (cnt_q == PWM_PERIOD_MAX);
        presc_d = presc_q + 16'd1;
        cnt_d   = cnt_q;
        if (!en_i) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            cnt_d   = wrap_o ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/apb_led_pwm.sv
// APB3 LED PWM peripheral with period-boundary duty commit.
// Optional interrupt output enabled by defining APB_LED_PWM_IRQ_EN.
module apb_led_pwm
    import apb_led_pwm_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_CH     = 8
) (
    input  logic                  io_systemClk,
    input  logic                  io_systemReset,
    input  logic [ADDR_WIDTH-1:0] io_apbSlave_0_PADDR,
    input  logic                  io_apbSlave_0_PSEL,
    input  logic                  io_apbSlave_0_PENABLE,
    input  logic                  io_apbSlave_0_PWRITE,
    input  logic [31:0]           io_apbSlave_0_PWDATA,
    output logic [31:0]           io_apbSlave_0_PRDATA,
    output logic                  io_apbSlave_0_PREADY,
    output logic                  io_apbSlave_0_PSLVERROR,
    output logic [NUM_CH-1:0]     o_pwm,
`ifdef APB_LED_PWM_IRQ_EN
    output logic                  o_irq,
`endif
    output logic                  o_period_tick
);

`ifdef APB_LED_PWM_IRQ_EN
    localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
    localparam logic [2:0] CTRL_WMASK = 3'b011;
`endif

    reg_sel_e          sel;
    logic              access, wr;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [15:0]       prescale_q, prescale_d;
    logic [31:0]       duty_lo_q, duty_lo_d, duty_hi_q, duty_hi_d;
    logic [63:0]       active_q, active_d;
    logic              period_q, period_d;
    logic              wrap_dly_q, tick_q;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [7:0]        cnt;
    logic              wrap, en, inv;
    logic              unused_addr;

    assign sel         = decode_reg(io_apbSlave_0_PADDR[7:2]);
    assign access      = io_apbSlave_0_PSEL && io_apbSlave_0_PENABLE;
    assign wr          = access && io_apbSlave_0_PWRITE;
    assign en          = ctrl_q[CTRL_EN];
    assign inv         = ctrl_q[CTRL_INV];
    assign unused_addr = ^{io_apbSlave_0_PADDR[ADDR_WIDTH-1:8], io_apbSlave_0_PADDR[1:0]};

    pwm_timebase u_timebase (
        .clk_i      (io_systemClk),
        .rst_i      (io_systemReset),
        .en_i       (en),
        .prescale_i (prescale_q),
        .cnt_o      (cnt),
        .wrap_o     (wrap)
    );

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        duty_lo_d  = duty_lo_q;
        duty_hi_d  = duty_hi_q;
        if (wr) begin
            case (sel)
                REG_CTRL:     ctrl_d     = io_apbSlave_0_PWDATA[2:0] & CTRL_WMASK;
                REG_PRESCALE: prescale_d = io_apbSlave_0_PWDATA[15:0];
                REG_DUTY_LO:  duty_lo_d  = io_apbSlave_0_PWDATA;
                REG_DUTY_HI:  duty_hi_d  = io_apbSlave_0_PWDATA;
                default:      ;
            endcase
        end
        // A wrap in the same cycle as a W1C keeps the flag set.
        period_d = period_q;
        if (wrap)
            period_d = 1'b1;
        else if (wr && sel == REG_STATUS && io_apbSlave_0_PWDATA[0])
            period_d = 1'b0;
        // Active duties take the pre-write shadow, so a write at a wrap lands next period.
        active_d = (!en || wrap) ? {duty_hi_q, duty_lo_q} : active_q;
        pwm_d    = {NUM_CH{inv}};
        if (en) begin
            for (int n = 0; n < NUM_CH; n++)
                pwm_d[n] = (cnt < active_q[8*n +: 8]) ^ inv;
        end
    end

    // Tick is delayed twice so it lines up with o_pwm showing count 0.
    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            duty_lo_q  <= '0;
            duty_hi_q  <= '0;
            active_q   <= '0;
            period_q   <= 1'b0;
            wrap_dly_q <= 1'b0;
            tick_q     <= 1'b0;
            pwm_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            duty_lo_q  <= duty_lo_d;
            duty_hi_q  <= duty_hi_d;
            active_q   <= active_d;
            period_q   <= period_d;
            wrap_dly_q <= wrap;
            tick_q     <= wrap_dly_q;
            pwm_q      <= pwm_d;
        end
    end

`ifdef APB_LED_PWM_IRQ_EN
    logic irq_q;

    always_ff @(posedge io_systemClk) begin
        if (io_systemReset)
            irq_q <= 1'b0;
        else
            irq_q <= period_q && ctrl_q[CTRL_IRQ_EN];
    end

    assign o_irq = irq_q;
`endif

    always_comb begin
        io_apbSlave_0_PRDATA    = '0;
        io_apbSlave_0_PSLVERROR = 1'b0;
        if (access) begin
            case (sel)
                REG_CTRL:     io_apbSlave_0_PRDATA = {29'h0, ctrl_q};
                REG_PRESCALE: io_apbSlave_0_PRDATA = {16'h0, prescale_q};
                REG_DUTY_LO:  io_apbSlave_0_PRDATA = duty_lo_q;
                REG_DUTY_HI:  io_apbSlave_0_PRDATA = duty_hi_q;
                REG_STATUS:   io_apbSlave_0_PRDATA = {16'h0, cnt, 7'h0, period_q};
                default:      io_apbSlave_0_PSLVERROR = 1'b1;
            endcase
        end
    end

    assign io_apbSlave_0_PREADY = 1'b1;
    assign o_pwm                = pwm_q;
    assign o_period_tick        = tick_q;

endmodule

// File: tb/tb_apb_led_pwm.sv
// Self-checking bench for apb_led_pwm: register vectors, directed PWM sequences, randomized runs.
module tb_apb_led_pwm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic [7:0]  pwm;
    logic        ptick;
`ifdef APB_LED_PWM_IRQ_EN
    logic        irq;
    localparam logic [31:0] CTRL_RB = 32'h6;
`else
    localparam logic [31:0] CTRL_RB = 32'h2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb_led_pwm dut (
        .io_systemClk            (clk),
        .io_systemReset          (rst),
        .io_apbSlave_0_PADDR     (paddr),
        .io_apbSlave_0_PSEL      (psel),
        .io_apbSlave_0_PENABLE   (penable),
        .io_apbSlave_0_PWRITE    (pwrite),
        .io_apbSlave_0_PWDATA    (pwdata),
        .io_apbSlave_0_PRDATA    (prdata),
        .io_apbSlave_0_PREADY    (pready),
        .io_apbSlave_0_PSLVERROR (pslverr),
        .o_pwm                   (pwm),
`ifdef APB_LED_PWM_IRQ_EN
        .o_irq                   (irq),
`endif
        .o_period_tick           (ptick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #1 err = pslverr;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata; err = pslverr;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        tbl[19];
    logic        e;
    logic [31:0] rd;
    logic [7:0]  duty[8];
    logic [7:0]  exp_pwm;
    int          c0, c7, cother, bad, n, p, lim;
    logic        inv, found;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{16'h0000, 1'b0, 32'h0, 32'h0, 1'b0};
        tbl[1]  = '{16'h0004, 1'b0, 32'h0, 32'h0, 1'b0};
        tbl[2]  = '{16'h0008, 1'b0, 32'h0, 32'h0, 1'b0};
        tbl[3]  = '{16'h000C, 1'b0, 32'h0, 32'h0, 1'b0};
        tbl[4]  = '{16'h0010, 1'b0, 32'h0, 32'h0, 1'b0};
        tbl[5]  = '{16'h0020, 1'b0, 32'h0, 32'h0, 1'b1};
        tbl[6]  = '{16'h0004, 1'b1, 32'hABCD1234, 32'h0, 1'b0};
        tbl[7]  = '{16'h0004, 1'b0, 32'h0, 32'h00001234, 1'b0};
        tbl[8]  = '{16'h0008, 1'b1, 32'h11223344, 32'h0, 1'b0};
        tbl[9]  = '{16'h0008, 1'b0, 32'h0, 32'h11223344, 1'b0};
        tbl[10] = '{16'h000C, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0};
        tbl[11] = '{16'h000C, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0};
        tbl[12] = '{16'h0020, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1};
        tbl[13] = '{16'h0108, 1'b0, 32'h0, 32'h11223344, 1'b0};
        tbl[14] = '{16'h0000, 1'b1, 32'hFFFFFFFE, 32'h0, 1'b0};
        tbl[15] = '{16'h0000, 1'b0, 32'h0, CTRL_RB, 1'b0};
        tbl[16] = '{16'h0010, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0};
        tbl[17] = '{16'h0010, 1'b0, 32'h0, 32'h0, 1'b0};
        tbl[18] = '{16'h000A, 1'b0, 32'h0, 32'h11223344, 1'b0};

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pwm", 32'(pwm), 32'h0);
        check("reset_tick", 32'(ptick), 32'h0);
        check("reset_pready", 32'(pready), 32'h1);
        rst = 1'b0;

        // Register vectors
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].wr) begin
                apb_write(tbl[i].addr, tbl[i].wdata, e);
                check($sformatf("vec%0d_werr", i), 32'(e), 32'(tbl[i].exp_err));
            end else begin
                apb_read(tbl[i].addr, rd, e);
                check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
                check($sformatf("vec%0d_rerr", i), 32'(e), 32'(tbl[i].exp_err));
            end
        end
        repeat (2) @(negedge clk);
        check("inv_disabled_pwm", 32'(pwm), 32'hFF);

        // One full period at PRESCALE=0
        apb_write(16'h00, 32'h0, e);
        apb_write(16'h04, 32'h0, e);
        apb_write(16'h08, 32'h000000FF, e);
        apb_write(16'h0C, 32'h80000000, e);
        apb_write(16'h00, 32'h1, e);
        c0 = 0; c7 = 0; cother = 0;
        for (int k = 0; k <= 255; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                c0 += int'(pwm[0]);
                c7 += int'(pwm[7]);
                cother += int'(|pwm[6:1]);
            end
        end
        check("period_ch0_high", 32'(c0), 32'd255);
        check("period_ch7_high", 32'(c7), 32'd128);
        check("period_other_high", 32'(cother), 32'd0);

        // Mid-period duty write only takes effect at the next period tick
        repeat (20) @(negedge clk);
        apb_write(16'h08, 32'h00000010, e);
        bad = 0; found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(negedge clk);
            if (ptick) found = 1'b1;
            else if (pwm[0] !== 1'b1) bad++;
        end
        check("shadow_tick_seen", 32'(found), 32'h1);
        check("shadow_hold_old", 32'(bad), 32'd0);
        c0 = int'(pwm[0]);
        for (int k = 1; k < 255; k++) begin
            @(negedge clk);
            c0 += int'(pwm[0]);
        end
        check("shadow_new_high", 32'(c0), 32'd16);

        // W1C landing exactly on the wrap edge
        apb_write(16'h00, 32'h0, e);
        apb_write(16'h10, 32'h1, e);
        apb_write(16'h04, 32'h0, e);
        apb_write(16'h00, 32'h1, e);
        repeat (253) @(posedge clk);
        apb_write(16'h10, 32'h1, e);
        apb_read(16'h10, rd, e);
        check("w1c_race_period", 32'(rd[0]), 32'h1);
        apb_write(16'h10, 32'h1, e);
        apb_read(16'h10, rd, e);
        check("w1c_clear_period", 32'(rd[0]), 32'h0);

`ifdef APB_LED_PWM_IRQ_EN
        apb_write(16'h00, 32'h5, e);
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(negedge clk);
            if (ptick) found = 1'b1;
        end
        check("irq_tick_seen", 32'(found), 32'h1);
        check("irq_after_wrap", 32'(irq), 32'h1);
        apb_write(16'h10, 32'h1, e);
        @(negedge clk);
        @(negedge clk);
        check("irq_cleared", 32'(irq), 32'h0);
`endif

        // Randomized runs against an arithmetic model of the period
        for (int it = 0; it < 3; it++) begin
            p   = (it == 0) ? 3 : int'($urandom_range(0, 3));
            inv = 1'($urandom_range(0, 1));
            for (int ch = 0; ch < 8; ch++) duty[ch] = 8'($urandom_range(0, 255));
            duty[1] = 8'hFF;
            duty[2] = 8'h00;
            apb_write(16'h00, {30'h0, inv, 1'b0}, e);
            apb_write(16'h10, 32'h1, e);
            apb_write(16'h04, 32'(p), e);
            apb_write(16'h08, {duty[3], duty[2], duty[1], duty[0]}, e);
            apb_write(16'h0C, {duty[7], duty[6], duty[5], duty[4]}, e);
            apb_write(16'h00, {30'h0, inv, 1'b1}, e);
            psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 16'h0010;
            lim = 255 * (p + 1) + 2 * (p + 1) + 5;
            for (int k = 0; k <= lim; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    exp_pwm = {8{inv}};
                end else begin
                    for (int ch = 0; ch < 8; ch++)
                        exp_pwm[ch] = (((k - 1) / (p + 1)) % 255 < int'(duty[ch])) ^ inv;
                end
                check($sformatf("rnd%0d_k%0d_pwm", it, k), 32'(pwm), 32'(exp_pwm));
                check($sformatf("rnd%0d_k%0d_status", it, k), prdata,
                      {16'h0, 8'((k / (p + 1)) % 255), 7'h0, 1'(k >= 255 * (p + 1))});
                check($sformatf("rnd%0d_k%0d_tick", it, k), 32'(ptick),
                      32'((k > 1) && ((k - 1) % (255 * (p + 1)) == 0)));
            end
            @(negedge clk);
            psel = 1'b0; penable = 1'b0;
        end

        // Tick spacing at PRESCALE=3, then reset mid-period
        apb_write(16'h00, 32'h0, e);
        apb_write(16'h04, 32'h3, e);
        apb_write(16'h08, 32'h80808080, e);
        apb_write(16'h00, 32'h3, e);
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            if (ptick) found = 1'b1;
        end
        check("spacing_first_tick", 32'(found), 32'h1);
        found = 1'b0; n = 0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            n++;
            if (ptick) found = 1'b1;
        end
        check("spacing_cycles", 32'(n), 32'd1020);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_pwm", 32'(pwm), 32'h0);
        check("midreset_tick", 32'(ptick), 32'h0);
        rst = 1'b0;
        apb_read(16'h00, rd, e);
        check("midreset_ctrl", rd, 32'h0);
        apb_read(16'h10, rd, e);
        check("midreset_status", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
